mem_stage_sram_ctrl: RTL

- MEM stage of the 5-stage MIPS32 pipeline, directly downstream of the EXE/MEM pipeline register.
- Turns LW/SW requests into a req/ack handshake to an external word-wide SRAM.
- Asserts STALL so the upstream stages and the EXE/MEM register freeze for the whole access.
- Drives the memory-side inputs of the MEM/WB register.

---
 rtl/mem_stage_sram_ctrl_pkg.sv | 18 +
 rtl/mem_stage_sram_ctrl_addr_check.sv | 21 ++
 rtl/mem_stage_sram_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared MEM-stage constants: datapath widths, data-memory map and
// SRAM controller FSM encoding.
package mem_stage_sram_ctrl_pkg;

  localparam int WORD_LEN       = 32;
  localparam int REG_ADDR_LEN   = 5;
  localparam int SRAM_ADDR_LEN  = 16;
  localparam int DATA_BASE      = 1024;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage_sram_ctrl_addr_check.sv
// Byte address validation and translation into an SRAM word index
// relative to the start of data memory.
module mem_addr_check
  import mem_stage_sram_ctrl_pkg::*;
(
  input  logic [WORD_LEN-1:0]      i_addr,
  output logic                     o_bad,
  output logic [SRAM_ADDR_LEN-1:0] o_word_addr
);

  logic [WORD_LEN-1:0] w_diff;
  logic                w_misaligned;
  logic                w_below;

  assign w_diff       = i_addr - WORD_LEN'(DATA_BASE);
  assign w_misaligned = |i_addr[1:0];
  assign w_below      = i_addr < WORD_LEN'(DATA_BASE);
  assign o_bad        = w_misaligned | w_below;
  assign o_word_addr  = SRAM_ADDR_LEN'(w_diff >> 2);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: turns LW/SW into an SRAM req/ack transaction, stalls the
// front of the pipeline while it runs and feeds the MEM/WB register.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WB_EN_IN,
  input  logic                     MEM_READ_EN_IN,
  input  logic                     MEM_WRITE_EN_IN,
  input  logic [WORD_LEN-1:0]      ALU_RESULT_IN,
  input  logic [WORD_LEN-1:0]      SW_OPERAND_IN,
  input  logic [REG_ADDR_LEN-1:0]  DESTINATION_IN,
  input  logic [WORD_LEN-1:0]      SRAM_RDATA,
  input  logic                     SRAM_ACK,
  output logic                     SRAM_REQ,
  output logic                     SRAM_WE,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic [WORD_LEN-1:0]      SRAM_WDATA,
  output logic                     STALL,
  output logic                     WB_EN_OUT,
  output logic                     MEM_READ_EN_OUT,
  output logic [WORD_LEN-1:0]      ALU_RESULT_OUT,
  output logic [WORD_LEN-1:0]      MEM_DATA_OUT,
  output logic [REG_ADDR_LEN-1:0]  DESTINATION_OUT,
  output logic                     MEM_ERR
);

  mem_state_t              r_state;
  logic                    r_req;
  logic                    r_we;
  logic [SRAM_ADDR_LEN-1:0] r_addr;
  logic [WORD_LEN-1:0]     r_wdata;
  logic [WORD_LEN-1:0]     r_rdata;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_err;

  logic                     w_mem_op;
  logic                     w_bad;
  logic [SRAM_ADDR_LEN-1:0] w_word_addr;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     w_timeout;

  mem_addr_check u_addr_check (
    .i_addr      (ALU_RESULT_IN),
    .o_bad       (w_bad),
    .o_word_addr (w_word_addr)
  );

  assign w_mem_op  = MEM_READ_EN_IN | MEM_WRITE_EN_IN;
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout = w_cnt_nxt == CNT_W'(TIMEOUT_CYCLES);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mem_op && w_bad) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end else if (w_mem_op) begin
            r_state <= S_ACCESS;
            r_req   <= 1'b1;
            r_we    <= MEM_WRITE_EN_IN;
            r_addr  <= w_word_addr;
            r_wdata <= SW_OPERAND_IN;
            r_cnt   <= '0;
          end
        end
        S_ACCESS: begin
          if (SRAM_ACK) begin
            if (!r_we) r_rdata <= SRAM_RDATA;
            r_req   <= 1'b0;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_DONE: begin
          // inputs still hold the finished instruction, so never re-launch here
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SRAM_REQ        = r_req;
  assign SRAM_WE         = r_we;
  assign SRAM_ADDR       = r_addr;
  assign SRAM_WDATA      = r_wdata;
  assign MEM_DATA_OUT    = r_rdata;
  assign MEM_ERR         = r_err;
  assign STALL           = !RESET &
                           (((r_state == S_IDLE) & w_mem_op) |
                            (r_state == S_ACCESS));
  assign WB_EN_OUT       = WB_EN_IN & ~(MEM_READ_EN_IN & r_err);
  assign MEM_READ_EN_OUT = MEM_READ_EN_IN;
  assign ALU_RESULT_OUT  = ALU_RESULT_IN;
  assign DESTINATION_OUT = DESTINATION_IN;

endmodule
